ifu: RTL

Instruction fetch unit: upstream producer of the valid/ready instruction handshake consumed by the decode stage. It owns the PC and issues one instruction read per instruction on a single-outstanding AXI-lite-style read channel (AR/R). It holds the returned instruction until decode accepts it, then waits for the next PC from the retire/PC-update stage. It sits between instruction memory (or the arbiter) and the IDU, and implements the multicycle, one-instruction-in-flight model.

---
 rtl/ifu_pkg.sv | 35 +++
 rtl/ifu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned CPU_WIDTH       = 32;
    localparam int unsigned INS_WIDTH       = 32;
    localparam int unsigned FETCH_EXC_WIDTH = 2;
    localparam int unsigned IFU_STATE_WIDTH = 3;
    localparam int unsigned RRESP_WIDTH     = 2;

    localparam logic [CPU_WIDTH-1:0]   IFU_RST_PC = 32'h8000_0000;
    localparam logic [INS_WIDTH-1:0]   INS_NOP    = 32'h0000_0013;
    localparam logic [RRESP_WIDTH-1:0] RRESP_OKAY = 2'b00;

    // Exception code reported alongside each instruction handed to decode.
    typedef enum logic [FETCH_EXC_WIDTH-1:0] {
        FETCH_EXC_NONE = 2'd0,
        FETCH_EXC_ACC  = 2'd1,
        FETCH_EXC_MIS  = 2'd2
    } fetch_exc_e;

    // One-instruction-in-flight fetch sequence.
    typedef enum logic [IFU_STATE_WIDTH-1:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_NPC  = 3'd4
    } ifu_state_e;

    // Instruction addresses must be word aligned.
    function automatic logic pc_misaligned(input logic [CPU_WIDTH-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one AR/R read per instruction,
// holds the fetched word for decode, then waits for the next PC.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RST_PC = IFU_RST_PC
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    output logic                       o_mem_arvalid,
    output logic [CPU_WIDTH-1:0]       o_mem_araddr,
    input  logic                       i_mem_arready,
    input  logic                       i_mem_rvalid,
    input  logic [INS_WIDTH-1:0]       i_mem_rdata,
    input  logic [RRESP_WIDTH-1:0]     i_mem_rresp,
    output logic                       o_mem_rready,
    output logic [INS_WIDTH-1:0]       o_ins,
    output logic [CPU_WIDTH-1:0]       o_pc,
    output logic [FETCH_EXC_WIDTH-1:0] o_fetch_exc,
    output logic                       o_post_valid,
    input  logic                       i_post_ready,
    input  logic                       i_npc_valid,
    input  logic [CPU_WIDTH-1:0]       i_npc,
    output logic                       o_npc_ready
);

    ifu_state_e            state_q, state_d;
    logic [CPU_WIDTH-1:0]  pc_q, pc_d;
    logic [INS_WIDTH-1:0]  ins_q, ins_d;
    fetch_exc_e            exc_q, exc_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  post_valid_q, post_valid_d;
    logic                  npc_ready_q, npc_ready_d;

    // Next-state and datapath capture; inputs not relevant to the current state are ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        exc_d   = exc_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (i_mem_arready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = S_HOLD;
                    if (i_mem_rresp == RRESP_OKAY) begin
                        ins_d = i_mem_rdata;
                        exc_d = FETCH_EXC_NONE;
                    end else begin
                        ins_d = INS_NOP;
                        exc_d = FETCH_EXC_ACC;
                    end
                end
            end
            S_HOLD: begin
                if (i_post_ready) begin
                    state_d = S_NPC;
                end
            end
            S_NPC: begin
                if (i_npc_valid) begin
                    pc_d = i_npc;
                    if (pc_misaligned(i_npc)) begin
                        // Misaligned target never reaches memory; report it as a NOP with an exception.
                        ins_d   = INS_NOP;
                        exc_d   = FETCH_EXC_MIS;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Handshake flags are a registered decode of the next state, so they track the state exactly.
    always_comb begin
        arvalid_d    = (state_d == S_REQ);
        rready_d     = (state_d == S_WAIT);
        post_valid_d = (state_d == S_HOLD);
        npc_ready_d  = (state_d == S_NPC);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RST_PC;
            ins_q        <= INS_NOP;
            exc_q        <= FETCH_EXC_NONE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            post_valid_q <= 1'b0;
            npc_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ins_q        <= ins_d;
            exc_q        <= exc_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            post_valid_q <= post_valid_d;
            npc_ready_q  <= npc_ready_d;
        end
    end

    assign o_mem_arvalid = arvalid_q;
    assign o_mem_araddr  = pc_q;
    assign o_mem_rready  = rready_q;
    assign o_ins         = ins_q;
    assign o_pc          = pc_q;
    assign o_fetch_exc   = exc_q;
    assign o_post_valid  = post_valid_q;
    assign o_npc_ready   = npc_ready_q;

endmodule
